// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer: holds the PC, fetches one instruction per
// handshake and presents op/ra/rb until retired. Optional counter: FETCH_PERF_EN.
module fetch_unit #(
  parameter int OP    = 4,
  parameter int PC_W  = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_data,
  output logic [OP-1:0]    op,
  output logic [1:0]       ra,
  output logic [1:0]       rb,
  output logic             instr_valid,
  input  logic             instr_ack,
  input  logic             br,
  input  logic             j,
  input  logic             zero,
  input  logic [PC_W-1:0]  br_target,
  output logic [15:0]      retired_count
);

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next;
  logic [PC_W-1:0]   j_off;
  logic [WIDTH-1:0]  ir;
  logic              load_ir;
  logic              retire;

  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    retire     = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          load_ir    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ack) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // JI offset is the low nibble of IR, sign-extended to the PC width.
  assign j_off = {{(PC_W-4){ir[3]}}, ir[3:0]};

  always_comb begin
    pc_next = pc + PC_W'(1);
    if (j)
      pc_next = pc + j_off;
    else if (br && zero)
      pc_next = br_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (load_ir)
        ir <= imem_data;
      if (retire)
        pc <= pc_next;
    end
  end

  assign imem_addr   = pc;
  // Request is masked during reset so no fetch is issued while rst is held.
  assign imem_req    = (state == FETCH) && !rst;
  assign instr_valid = (state == ISSUE);
  assign op          = ir[WIDTH-1 -: OP];
  assign ra          = ir[3:2];
  assign rb          = ir[1:0];

`ifdef FETCH_PERF_EN
  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (retire)
      count <= count + 16'd1;
  end

  assign retired_count = count;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// reset/stall sequences and randomized instructions against a PC/count model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_addr;
  logic       imem_req;
  logic       imem_ready;
  logic [7:0] imem_data;
  logic [3:0] op;
  logic [1:0] ra, rb;
  logic       instr_valid;
  logic       instr_ack;
  logic       br, j, zero;
  logic [7:0] br_target;
  logic [15:0] retired_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  pc_m;
  int unsigned cnt_m;
  logic [7:0]  last_ir;

  fetch_unit #(.OP(4), .PC_W(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .op(op), .ra(ra), .rb(rb),
    .instr_valid(instr_valid), .instr_ack(instr_ack),
    .br(br), .j(j), .zero(zero), .br_target(br_target),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_count();
`ifdef FETCH_PERF_EN
    return cnt_m & 32'hFFFF;
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [7:0] instr,
                                            input logic b, input logic jj, input logic z,
                                            input logic [7:0] tgt);
    int off;
    off = (instr[3]) ? int'(instr[3:0]) - 16 : int'(instr[3:0]);
    if (jj)         return 8'(int'(pc) + off + 256);
    else if (b && z) return tgt;
    else            return 8'(int'(pc) + 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b0; instr_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_fields", {op, ra, rb}, 0);
    check("rst_count", retired_count, 0);
    rst = 1'b0;
    pc_m = 8'h00; cnt_m = 0; last_ir = 8'h00;
    #1 check("req_after_release", imem_req, 1);
  endtask

  // One instruction: rw memory wait cycles, aw ack-delay cycles.
  task automatic run_instr(input logic [7:0] instr, input int unsigned rw, input int unsigned aw,
                           input logic b, input logic jj, input logic z, input logic [7:0] tgt);
    for (int unsigned k = 0; k <= rw; k++) begin
      @(negedge clk);
      check("fetch_req", imem_req, 1);
      check("fetch_addr", imem_addr, pc_m);
      check("fetch_valid", instr_valid, 0);
      check("fetch_hold_fields", {op, ra, rb}, last_ir);
      imem_ready = (k == rw);
      imem_data  = (k == rw) ? instr : 8'($urandom);
      instr_ack  = 1'($urandom);
      {br, j, zero} = 3'($urandom);
      br_target  = 8'($urandom);
    end
    for (int unsigned k = 0; k <= aw; k++) begin
      @(negedge clk);
      check("issue_valid", instr_valid, 1);
      check("issue_req", imem_req, 0);
      check("issue_op", op, instr[7:4]);
      check("issue_rarb", {ra, rb}, instr[3:0]);
      check("issue_count", retired_count, exp_count());
      imem_ready = 1'($urandom);
      imem_data  = 8'($urandom);
      instr_ack  = (k == aw);
      if (k == aw) begin
        br = b; j = jj; zero = z; br_target = tgt;
      end else begin
        {br, j, zero} = 3'($urandom);
        br_target = 8'($urandom);
      end
    end
    pc_m    = model_next(pc_m, instr, b, jj, z, tgt);
    cnt_m   = cnt_m + 1;
    last_ir = instr;
  endtask

  typedef struct {
    bit          do_rst;
    logic [7:0]  instr;
    int unsigned rw, aw;
    logic        b, jj, z;
    logic [7:0]  tgt;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_data = '0; instr_ack = 1'b0;
    br = 1'b0; j = 1'b0; zero = 1'b0; br_target = '0;
    pc_m = '0; cnt_m = 0; last_ir = '0;

    vecs[0]  = '{1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    vecs[1]  = '{0, 8'h11, 0, 0, 0, 0, 0, 8'h00, 8'h02};
    vecs[2]  = '{0, 8'h22, 0, 0, 0, 0, 0, 8'h00, 8'h03};
    vecs[3]  = '{1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h01};
    vecs[4]  = '{0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h02};
    vecs[5]  = '{0, 8'h1C, 0, 0, 1, 1, 1, 8'h40, 8'hFE};
    vecs[6]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'hFF};
    vecs[7]  = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00};
    vecs[8]  = '{0, 8'h9A, 0, 0, 1, 0, 1, 8'h40, 8'h40};
    vecs[9]  = '{0, 8'h9A, 0, 0, 1, 0, 1, 8'h10, 8'h10};
    vecs[10] = '{0, 8'h9A, 0, 0, 1, 0, 0, 8'h80, 8'h11};
    vecs[11] = '{0, 8'h5B, 3, 2, 0, 0, 0, 8'h00, 8'h12};
    vecs[12] = '{0, 8'h07, 0, 0, 0, 1, 0, 8'h00, 8'h19};

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_rst) do_reset();
      run_instr(vecs[i].instr, vecs[i].rw, vecs[i].aw, vecs[i].b, vecs[i].jj, vecs[i].z, vecs[i].tgt);
      @(posedge clk);
      #1;
      check("vec_next_pc", imem_addr, vecs[i].exp_pc);
      if (i == 2) check("seq_count", retired_count, exp_count());
    end

    // Stall timing: 3 memory waits plus 2 ack-low cycles is 7 cycles per instruction.
    begin
      int unsigned t0, t1;
      t0 = n_cmp;
      @(negedge clk);
      instr_ack = 1'b0; imem_ready = 1'b0;
      begin
        int cyc;
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < 20) begin
          check("stall_addr", imem_addr, pc_m);
          @(negedge clk);
          cyc++;
          imem_ready = (cyc == 3);
          imem_data  = 8'h33;
        end
        check("stall_fetch_cycles", cyc, 4);
        imem_ready = 1'b0;
        cyc = 0;
        while (instr_valid === 1'b1 && cyc < 20) begin
          instr_ack = (cyc == 2);
          br = 1'b0; j = 1'b0;
          @(negedge clk);
          cyc++;
        end
        instr_ack = 1'b0;
        check("stall_issue_cycles", cyc, 3);
      end
      pc_m = model_next(pc_m, 8'h33, 0, 0, 0, 8'h00);
      cnt_m = cnt_m + 1; last_ir = 8'h33;
      check("stall_next_pc", imem_addr, pc_m);
      t1 = n_cmp;
      if (t1 == t0) n_bad++;
    end

    // Reset asserted together with ack while an instruction is presented.
    do_reset();
    run_instr(8'h00, 0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    imem_ready = 1'b1; imem_data = 8'h35; instr_ack = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    check("midrst_valid_before", instr_valid, 1);
    instr_ack = 1'b1; br = 1'b1; zero = 1'b1; br_target = 8'h77; rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", instr_valid, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_count", retired_count, 0);
    check("midrst_fields", {op, ra, rb}, 0);
    @(negedge clk);
    rst = 1'b0; instr_ack = 1'b0;
    pc_m = 8'h00; cnt_m = 0; last_ir = 8'h00;
    #1 check("midrst_req", imem_req, 1);

    for (int i = 0; i < 300; i++) begin
      run_instr(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    @(negedge clk);
    instr_ack = 1'b0;
    check("rand_final_addr", imem_addr, pc_m);
    check("rand_final_count", retired_count, exp_count());

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
